// File: rtl/serial_deserializer.sv
// Serial-in/parallel-out word assembler with a one-entry valid/ready output
// buffer and a sticky overrun flag for words dropped while the buffer is full.
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 3,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_en,
  input  logic             clear,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] shifted;
  logic             done;
  logic             buf_free;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign shifted = {sr[WIDTH-2:0], serial_in};
    end else begin : g_lsb
      assign shifted = {serial_in, sr[WIDTH-1:1]};
    end
  endgenerate

  // clear outranks a sample on the same edge, so it also suppresses completion
  assign done     = serial_en && !clear && (bit_cnt == LAST);
  assign buf_free = !out_valid || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr        <= '0;
      bit_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (clear) begin
        sr      <= '0;
        bit_cnt <= '0;
        overrun <= 1'b0;
      end else if (serial_en) begin
        sr      <= shifted;
        bit_cnt <= done ? '0 : bit_cnt + CNT_W'(1);
        if (done && !buf_free)
          overrun <= 1'b1;
      end

      // output buffer is independent of clear; refill wins over drain
      if (done && buf_free) begin
        out_data  <= shifted;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: MSB-first and LSB-first instances on shared
// inputs, checked against a bit-queue reference model.
module tb_serial_deserializer;
  localparam int W  = 8;
  localparam int CW = 3;

  logic clk = 0, reset = 1;
  logic serial_in = 0, serial_en = 0, clear = 0, out_ready = 0;
  logic [W-1:0]  d1, d0;
  logic          v1, v0, o1, o0;
  logic [CW-1:0] c1, c0;

  int checks = 0, errors = 0;

  // reference model state
  bit           bitq[$];
  logic [W-1:0] m_d1, m_d0;
  logic         m_v, m_o;

  serial_deserializer #(.WIDTH(W), .CNT_W(CW), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_en(serial_en),
    .clear(clear), .out_data(d1), .out_valid(v1), .out_ready(out_ready),
    .overrun(o1), .bit_cnt(c1));

  serial_deserializer #(.WIDTH(W), .CNT_W(CW), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_en(serial_en),
    .clear(clear), .out_data(d0), .out_valid(v0), .out_ready(out_ready),
    .overrun(o0), .bit_cnt(c0));

  always #5 clk = ~clk;

  task automatic model_reset();
    bitq.delete();
    m_d1 = '0; m_d0 = '0; m_v = 0; m_o = 0;
  endtask

  // drive one cycle, advance the model from the word-level rules, sample at +1
  task automatic step(input logic en, input logic b, input logic rdy, input logic clr);
    logic [W-1:0] w1, w0;
    logic xfer, refill;
    @(negedge clk);
    serial_en = en; serial_in = b; out_ready = rdy; clear = clr;
    @(posedge clk);
    xfer = m_v && rdy;
    refill = 0;
    if (clr) begin
      bitq.delete();
      m_o = 0;
    end else if (en) begin
      bitq.push_back(b);
      if (bitq.size() == W) begin
        w1 = '0; w0 = '0;
        for (int i = 0; i < W; i++) begin
          w1 = (w1 << 1) | W'(bitq[i]);
          w0 = w0 | (W'(bitq[i]) << i);
        end
        if (!m_v || rdy) begin
          m_d1 = w1; m_d0 = w0; refill = 1;
        end else m_o = 1;
        bitq.delete();
      end
    end
    if (refill) m_v = 1;
    else if (xfer) m_v = 0;
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy_last);
    for (int i = W - 1; i >= 0; i--) step(1'b1, w[i], (i == 0) ? rdy_last : 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; serial_en = 0; clear = 0; out_ready = 0;
    #1 reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1;
    #3;
    checks++;
    if ({v1, v0, o1, o0, c1, c0, d1, d0} !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b o=%b cnt=%0d d=%h d0=%h exp all 0", v1, o1, c1, d1, d0);
    end
    @(negedge clk) reset = 0;
    model_reset();
  endtask

  task automatic test_directed();
    logic [W-1:0] pat;
    pat = 8'b1011_0010;
    for (int i = 0; i < W; i++) begin
      step(1'b1, pat[W-1-i], 1'b0, 1'b0);
      if (i < W - 1) begin
        checks++;
        if (c1 !== CW'(i + 1) || v1 !== 1'b0) begin
          errors++;
          $display("FAIL directed_cnt edge %0d got cnt=%0d v=%b exp cnt=%0d v=0", i + 1, c1, v1, i + 1);
        end
      end
    end
    checks++;
    if (v1 !== 1 || v0 !== 1 || d1 !== 8'hB2 || d0 !== 8'h4D || c1 !== 0 || c0 !== 0) begin
      errors++;
      $display("FAIL directed_word got v=%b d=%h d0=%h cnt=%0d exp v=1 d=b2 d0=4d cnt=0", v1, d1, d0, c1);
    end
  endtask

  task automatic test_gapped();
    logic [W-1:0] pat;
    logic [CW-1:0] held;
    pat = 8'hA5;
    do_reset();
    for (int i = 0; i < W; i++) begin
      held = c1;
      for (int g = 0; g < 2; g++) begin
        step(1'b0, 1'($urandom), 1'b0, 1'b0);
        checks++;
        if (c1 !== held || v1 !== 1'b0) begin
          errors++;
          $display("FAIL gapped_hold bit %0d got cnt=%0d v=%b exp cnt=%0d v=0", i, c1, v1, held);
        end
      end
      step(1'b1, pat[W-1-i], 1'b0, 1'b0);
      if (i < W - 1) begin
        checks++;
        if (v1 !== 1'b0) begin
          errors++;
          $display("FAIL gapped_early_valid bit %0d got v=%b exp 0", i, v1);
        end
      end
    end
    checks++;
    if (v1 !== 1 || d1 !== 8'hA5 || d0 !== 8'hA5) begin
      errors++;
      $display("FAIL gapped_word got v=%b d=%h d0=%h exp v=1 d=a5 d0=a5", v1, d1, d0);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    send_word(8'h3C, 1'b0);
    send_word(8'hFF, 1'b0);
    checks++;
    if (o1 !== 1 || o0 !== 1 || v1 !== 1 || d1 !== 8'h3C || d0 !== m_d0) begin
      errors++;
      $display("FAIL bp_overrun got o=%b v=%b d=%h d0=%h exp o=1 v=1 d=3c d0=%h", o1, v1, d1, d0, m_d0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (v1 !== 0 || v0 !== 0 || d1 !== 8'h3C) begin
      errors++;
      $display("FAIL bp_drain got v=%b d=%h exp v=0 d=3c", v1, d1);
    end
    send_word(8'h81, 1'b0);
    checks++;
    if (v1 !== 1 || d1 !== 8'h81 || d0 !== 8'h81 || o1 !== 1) begin
      errors++;
      $display("FAIL bp_next got v=%b d=%h d0=%h o=%b exp v=1 d=81 d0=81 o=1", v1, d1, d0, o1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b1);
    checks++;
    if (v1 !== 1 || d1 !== 8'h22 || d0 !== 8'h44 || o1 !== 0 || o0 !== 0) begin
      errors++;
      $display("FAIL b2b_refill got v=%b d=%h d0=%h o=%b exp v=1 d=22 d0=44 o=0", v1, d1, d0, o1);
    end
  endtask

  task automatic test_clear();
    do_reset();
    send_word(8'h5A, 1'b0);
    send_word(8'h77, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (c1 !== 3'd5 || o1 !== 1) begin
      errors++;
      $display("FAIL clear_pre got cnt=%0d o=%b exp cnt=5 o=1", c1, o1);
    end
    // clear with a sample and a handshake on the same edge
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (c1 !== 0 || c0 !== 0 || o1 !== 0 || o0 !== 0 || v1 !== 0 || d1 !== 8'h5A) begin
      errors++;
      $display("FAIL clear_edge got cnt=%0d o=%b v=%b d=%h exp cnt=0 o=0 v=0 d=5a", c1, o1, v1, d1);
    end
    send_word(8'hC3, 1'b0);
    checks++;
    if (v1 !== 1 || d1 !== 8'hC3 || d0 !== 8'hC3 || o1 !== 0) begin
      errors++;
      $display("FAIL clear_clean got v=%b d=%h d0=%h o=%b exp v=1 d=c3 d0=c3 o=0", v1, d1, d0, o1);
    end
  endtask

  task automatic test_async_reset();
    send_word(8'hE7, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1;
    #1;
    checks++;
    if ({v1, v0, o1, o0, c1, c0, d1, d0} !== '0) begin
      errors++;
      $display("FAIL async_reset got v=%b o=%b cnt=%0d d=%h exp all 0", v1, o1, c1, d1);
    end
    #1 reset = 0;
    model_reset();
  endtask

  task automatic test_random();
    logic en, b, rdy, clr;
    for (int n = 0; n < 400; n++) begin
      en  = ($urandom_range(3) != 0);
      b   = 1'($urandom);
      rdy = ($urandom_range(3) == 0);
      clr = ($urandom_range(29) == 0);
      step(en, b, rdy, clr);
      checks++;
      if (v1 !== m_v || v0 !== m_v || o1 !== m_o || o0 !== m_o ||
          c1 !== CW'(bitq.size()) || c0 !== CW'(bitq.size()) ||
          (m_v && (d1 !== m_d1 || d0 !== m_d0))) begin
        errors++;
        $display("FAIL random cyc %0d got v=%b o=%b cnt=%0d d=%h d0=%h exp v=%b o=%b cnt=%0d d=%h d0=%h",
                 n, v1, o1, c1, d1, d0, m_v, m_o, bitq.size(), m_d1, m_d0);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_directed();
    test_gapped();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
